// File: rtl/bus_stream_target_if.sv
// Request/ready word bus plus valid/ready output stream for bus_stream_target.
// No storage: pure signal bundle, no latency.
// Backpressure is carried by ready (bus side) and stream_ready (stream side).
interface bus_stream_target_if;
    logic        request;
    logic        rw;
    logic [1:0]  address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        stream_valid;
    logic [31:0] stream_data;
    logic        stream_ready;
    logic        irq;

    // Bus master that also acts as the stream sink.
    modport master (
        output request, rw, address, wdata, stream_ready,
        input  rdata, ready, stream_valid, stream_data, irq
    );

    // The target block.
    modport slave (
        input  request, rw, address, wdata, stream_ready,
        output rdata, ready, stream_valid, stream_data, irq
    );
endinterface

// File: rtl/bus_stream_target.sv
// Generic first-word-fall-through FIFO with occupancy level and single-cycle flush.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: pushes are dropped while full; callers must check full before pushing.
module bus_stream_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int PW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    input  logic             flush,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    // Flush wins over both a push and a pop in the same cycle.
    assign push_ok  = push_vld && !full && !flush;
    assign pop_ok   = !empty && pop_rdy && !flush;
    assign head_vld = !empty;
    assign head_dat = mem[rd_ptr];
    assign level    = level_q;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge i_clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

// Bus target that queues reg-0 word writes into a FIFO and streams them out.
// Latency: ready one cycle after request is sampled; stream head one cycle after push.
// Backpressure: a push to a full FIFO stalls (ready withheld) until a word is popped.
module bus_stream_target #(
    parameter int DEPTH = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    bus_stream_target_if.slave    bus
);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_nxt;
    logic           ready_q;
    logic           ready_nxt;
    logic [31:0]    rdata_q;
    logic [31:0]    rdata_nxt;
    logic [LW-1:0]  thr_q;
    logic [LW-1:0]  thr_nxt;
    logic [31:0]    cnt_q;
    logic [31:0]    cnt_nxt;
    logic           irq_q;

    logic           push_vld;
    logic           flush;
    logic [LW-1:0]  fifo_level;
    logic           fifo_full;
    logic           fifo_empty;

    bus_stream_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .push_vld  (push_vld),
        .push_dat  (bus.wdata),
        .pop_rdy   (bus.stream_ready),
        .flush     (flush),
        .head_vld  (bus.stream_valid),
        .head_dat  (bus.stream_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign bus.irq   = irq_q;

    // State and register file; reset also drops ready mid-access and abandons any stall.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
            thr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            ready_q <= ready_nxt;
            rdata_q <= rdata_nxt;
            thr_q   <= thr_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Refill interrupt, one cycle behind the level it is judged on.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            irq_q <= 1'b1;
        end else begin
            irq_q <= (fifo_level <= thr_q);
        end
    end

    // Access sequencing: decode in IDLE, wait for room in STALL, hold ready in ACK.
    always_comb begin
        state_nxt = state_q;
        ready_nxt = ready_q;
        rdata_nxt = rdata_q;
        thr_nxt   = thr_q;
        cnt_nxt   = cnt_q;
        push_vld  = 1'b0;
        flush     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.request) begin
                    if (bus.rw && (bus.address == 2'd0) && fifo_full) begin
                        state_nxt = STALL;
                    end else begin
                        ready_nxt = 1'b1;
                        state_nxt = ACK;
                        rdata_nxt = '0;
                        if (bus.rw) begin
                            case (bus.address)
                                2'd0: begin
                                    push_vld = 1'b1;
                                    cnt_nxt  = cnt_q + 32'd1;
                                end
                                2'd1: thr_nxt = bus.wdata[LW-1:0];
                                2'd2: flush   = bus.wdata[0];
                                2'd3: begin
                                    if (bus.wdata[0]) begin
                                        cnt_nxt = '0;
                                    end
                                end
                            endcase
                        end else begin
                            case (bus.address)
                                2'd0: rdata_nxt = cnt_q;
                                2'd1: rdata_nxt = 32'(thr_q);
                                2'd2: rdata_nxt = 32'(fifo_level);
                                2'd3: rdata_nxt = {29'd0, irq_q, fifo_full, fifo_empty};
                            endcase
                        end
                    end
                end
            end
            STALL: begin
                if (!bus.request) begin
                    // Master gave up; the held word is never pushed.
                    state_nxt = IDLE;
                end else if (!fifo_full) begin
                    push_vld  = 1'b1;
                    cnt_nxt   = cnt_q + 32'd1;
                    ready_nxt = 1'b1;
                    rdata_nxt = '0;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!bus.request) begin
                    ready_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_bus_stream_target.sv
// Directed self-checking bench for bus_stream_target (DEPTH = 16).
// Inputs driven and outputs sampled on the falling clock edge.
// Stream words are logged on each rising-edge handshake for ordering checks.
module tb_bus_stream_target;
    logic clk;
    logic rst_n;

    bus_stream_target_if bus ();

    bus_stream_target #(.DEPTH(16)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] popped [$];
    logic [31:0] rd;
    logic        ok;
    int          nok;
    logic        got;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus.stream_valid && bus.stream_ready) begin
            popped.push_back(bus.stream_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete bus access with a bounded wait for ready.
    task automatic access(input logic w, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] rdo, output logic oko);
        @(negedge clk);
        bus.request = 1'b1;
        bus.rw      = w;
        bus.address = a;
        bus.wdata   = d;
        oko = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                oko = 1'b1;
                break;
            end
        end
        rdo = bus.rdata;
        bus.request = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus.request      = 1'b0;
        bus.rw           = 1'b0;
        bus.address      = 2'd0;
        bus.wdata        = '0;
        bus.stream_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_svalid", 32'(bus.stream_valid), 32'd0);
        check("rst_irq", 32'(bus.irq), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        access(1'b0, 2'd3, 32'd0, rd, ok);
        check("rst_status", rd, 32'h5);
        access(1'b0, 2'd1, 32'd0, rd, ok);
        check("rst_thr", rd, 32'd0);

        // 1: three words stream out in order
        bus.stream_ready = 1'b1;
        popped.delete();
        access(1'b1, 2'd0, 32'hA, rd, ok);
        check("t1_push_a", 32'(ok), 32'd1);
        access(1'b1, 2'd0, 32'hB, rd, ok);
        access(1'b1, 2'd0, 32'hC, rd, ok);
        repeat (3) @(negedge clk);
        check("t1_npop", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            check("t1_w0", popped[0], 32'hA);
            check("t1_w1", popped[1], 32'hB);
            check("t1_w2", popped[2], 32'hC);
        end
        access(1'b0, 2'd0, 32'd0, rd, ok);
        check("t1_count", rd, 32'd3);

        // 2: handshake timing
        @(negedge clk);
        bus.request = 1'b1;
        bus.rw      = 1'b0;
        bus.address = 2'd1;
        check("t2_ready_pre", 32'(bus.ready), 32'd0);
        @(negedge clk);
        check("t2_ready_n1", 32'(bus.ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("t2_ready_hold", 32'(bus.ready), 32'd1);
        end
        bus.request = 1'b0;
        @(negedge clk);
        check("t2_ready_drop", 32'(bus.ready), 32'd0);

        // 3: fill to full, 17th push stalls until a pop
        bus.stream_ready = 1'b0;
        popped.delete();
        nok = 0;
        for (int i = 0; i < 16; i++) begin
            access(1'b1, 2'd0, 32'h100 + 32'(i), rd, ok);
            if (ok) nok++;
        end
        check("t3_fill_ok", 32'(nok), 32'd16);
        access(1'b0, 2'd3, 32'd0, rd, ok);
        check("t3_status_full", rd, 32'h2);
        @(negedge clk);
        bus.request = 1'b1;
        bus.rw      = 1'b1;
        bus.address = 2'd0;
        bus.wdata   = 32'h1FF;
        repeat (3) @(negedge clk);
        check("t3_stalled", 32'(bus.ready), 32'd0);
        bus.stream_ready = 1'b1;
        @(negedge clk);
        bus.stream_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                got = 1'b1;
                break;
            end
        end
        check("t3_unstall", 32'(got), 32'd1);
        bus.request = 1'b0;
        @(negedge clk);
        bus.stream_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("t3_npop", 32'(popped.size()), 32'd17);
        if (popped.size() == 17) begin
            check("t3_first", popped[0], 32'h100);
            check("t3_16th", popped[15], 32'h10F);
            check("t3_last", popped[16], 32'h1FF);
        end
        access(1'b0, 2'd0, 32'd0, rd, ok);
        check("t3_count", rd, 32'd20);

        // 4: threshold interrupt
        bus.stream_ready = 1'b0;
        access(1'b1, 2'd1, 32'd4, rd, ok);
        for (int i = 0; i < 6; i++) begin
            access(1'b1, 2'd0, 32'h200 + 32'(i), rd, ok);
        end
        @(negedge clk);
        check("t4_irq_lvl6", 32'(bus.irq), 32'd0);
        bus.stream_ready = 1'b1;
        @(negedge clk);
        check("t4_irq_lvl5", 32'(bus.irq), 32'd0);
        @(negedge clk);
        bus.stream_ready = 1'b0;
        check("t4_irq_lag", 32'(bus.irq), 32'd0);
        @(negedge clk);
        check("t4_irq_lvl4", 32'(bus.irq), 32'd1);
        access(1'b0, 2'd2, 32'd0, rd, ok);
        check("t4_level", rd, 32'd4);

        // 5: flush and count clear
        access(1'b1, 2'd2, 32'd1, rd, ok);
        access(1'b0, 2'd2, 32'd0, rd, ok);
        check("t5_flush0", rd, 32'd0);
        access(1'b1, 2'd3, 32'd1, rd, ok);
        for (int i = 0; i < 5; i++) begin
            access(1'b1, 2'd0, 32'h300 + 32'(i), rd, ok);
        end
        access(1'b0, 2'd0, 32'd0, rd, ok);
        check("t5_count5", rd, 32'd5);
        access(1'b1, 2'd2, 32'd2, rd, ok);
        access(1'b0, 2'd2, 32'd0, rd, ok);
        check("t5_noflush", rd, 32'd5);
        access(1'b1, 2'd2, 32'd1, rd, ok);
        check("t5_svalid", 32'(bus.stream_valid), 32'd0);
        access(1'b0, 2'd2, 32'd0, rd, ok);
        check("t5_level0", rd, 32'd0);
        access(1'b0, 2'd0, 32'd0, rd, ok);
        check("t5_count_kept", rd, 32'd5);
        access(1'b1, 2'd3, 32'd1, rd, ok);
        access(1'b0, 2'd0, 32'd0, rd, ok);
        check("t5_count_clr", rd, 32'd0);

        // 6: reset while stalled, then while acknowledging
        nok = 0;
        for (int i = 0; i < 16; i++) begin
            access(1'b1, 2'd0, 32'h400 + 32'(i), rd, ok);
            if (ok) nok++;
        end
        check("t6_fill_ok", 32'(nok), 32'd16);
        @(negedge clk);
        bus.request = 1'b1;
        bus.rw      = 1'b1;
        bus.address = 2'd0;
        bus.wdata   = 32'h4FF;
        repeat (3) @(negedge clk);
        check("t6_stalled", 32'(bus.ready), 32'd0);
        check("t6_svalid_pre", 32'(bus.stream_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_svalid", 32'(bus.stream_valid), 32'd0);
        check("t6_rst_ready", 32'(bus.ready), 32'd0);
        check("t6_rst_irq", 32'(bus.irq), 32'd1);
        bus.request = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.request = 1'b1;
        bus.rw      = 1'b0;
        bus.address = 2'd1;
        @(negedge clk);
        check("t6_ack_ready", 32'(bus.ready), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_ack_rst_ready", 32'(bus.ready), 32'd0);
        bus.request = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.stream_ready = 1'b1;
        popped.delete();
        access(1'b1, 2'd0, 32'h77, rd, ok);
        check("t6_push_ok", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        check("t6_npop", 32'(popped.size()), 32'd1);
        if (popped.size() == 1) begin
            check("t6_word", popped[0], 32'h77);
        end
        access(1'b0, 2'd0, 32'd0, rd, ok);
        check("t6_count", rd, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
